// File: rtl/umul_arb_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
package umul_arb_pkg;
    localparam int OPERAND_WIDTH = 8;
    localparam int RESULT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        RESULT = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the pointer wins.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);
    always_comb begin
        int j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/unsigned_multiplier_arbiter.sv
// Time-shares one external 8x8 multiplier among NUM_REQ clients; one operation
// takes IDLE -> EXEC -> RESULT, with the product returned on a tagged response channel.
module unsigned_multiplier_arbiter
    import umul_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                               Clock_In,
    input  logic                               Reset_N_In,
    input  logic [NUM_REQ-1:0]                 Req_Valid_In,
    output logic [NUM_REQ-1:0]                 Req_Ready_Out,
    input  logic [OPERAND_WIDTH*NUM_REQ-1:0]   Req_Data_A_In,
    input  logic [OPERAND_WIDTH*NUM_REQ-1:0]   Req_Data_B_In,
    output logic                               Mult_Enable_Out,
    output logic [OPERAND_WIDTH-1:0]           Mult_Data_A_Out,
    output logic [OPERAND_WIDTH-1:0]           Mult_Data_B_Out,
    input  logic [RESULT_WIDTH-1:0]            Mult_Result_In,
    output logic                               Resp_Valid_Out,
    input  logic                               Resp_Ready_In,
    output logic [RESULT_WIDTH-1:0]            Resp_Result_Out,
    output logic [ID_WIDTH-1:0]                Resp_Id_Out,
    output logic [15:0]                        Ops_Count_Out
);
    state_t                     r_state;
    logic [ID_WIDTH-1:0]        r_rr_ptr;
    logic [ID_WIDTH-1:0]        r_id;
    logic [OPERAND_WIDTH-1:0]   r_a;
    logic [OPERAND_WIDTH-1:0]   r_b;
    logic [RESULT_WIDTH-1:0]    r_result;
    logic [15:0]                r_ops_count;

    logic [NUM_REQ-1:0]         w_grant;
    logic [ID_WIDTH-1:0]        w_idx;
    logic                       w_any;
    logic                       w_in_idle;
    logic [OPERAND_WIDTH-1:0]   w_a_sel;
    logic [OPERAND_WIDTH-1:0]   w_b_sel;
    logic [ID_WIDTH-1:0]        w_ptr_next;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_WIDTH)
    ) u_rr_arbiter (
        .i_req   (Req_Valid_In),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Grants are suppressed while reset is held so nothing looks accepted in that cycle.
    assign w_in_idle     = (r_state == IDLE) && Reset_N_In;
    assign Req_Ready_Out = w_in_idle ? w_grant : '0;

    assign w_a_sel    = Req_Data_A_In[OPERAND_WIDTH*w_idx +: OPERAND_WIDTH];
    assign w_b_sel    = Req_Data_B_In[OPERAND_WIDTH*w_idx +: OPERAND_WIDTH];
    assign w_ptr_next = ID_WIDTH'((int'(w_idx) + 1) % NUM_REQ);

    always_ff @(posedge Clock_In) begin
        if (!Reset_N_In) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_ops_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a      <= w_a_sel;
                        r_b      <= w_b_sel;
                        r_id     <= w_idx;
                        r_rr_ptr <= w_ptr_next;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= Mult_Result_In;
                    r_state  <= RESULT;
                end
                RESULT: begin
                    if (Resp_Ready_In) begin
                        r_ops_count <= r_ops_count + 16'd1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operand outputs stay on the latched values outside EXEC to avoid toggling the array.
    assign Mult_Enable_Out = (r_state == EXEC);
    assign Mult_Data_A_Out = r_a;
    assign Mult_Data_B_Out = r_b;
    assign Resp_Valid_Out  = (r_state == RESULT);
    assign Resp_Result_Out = r_result;
    assign Resp_Id_Out     = r_id;
    assign Ops_Count_Out   = r_ops_count;
endmodule

// File: tb/tb_unsigned_multiplier_arbiter.sv
// Scoreboard bench for unsigned_multiplier_arbiter with a behavioural multiplier attached.
module tb_unsigned_multiplier_arbiter;
    logic        Clock_In = 1'b0;
    logic        Reset_N_In;
    logic [3:0]  Req_Valid_In;
    logic [3:0]  Req_Ready_Out;
    logic [31:0] Req_Data_A_In;
    logic [31:0] Req_Data_B_In;
    logic        Mult_Enable_Out;
    logic [7:0]  Mult_Data_A_Out;
    logic [7:0]  Mult_Data_B_Out;
    logic [15:0] Mult_Result_In;
    logic        Resp_Valid_Out;
    logic        Resp_Ready_In;
    logic [15:0] Resp_Result_Out;
    logic [1:0]  Resp_Id_Out;
    logic [15:0] Ops_Count_Out;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] res;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 Clock_In = ~Clock_In;

    // Garbage when disabled so a capture at the wrong cycle shows up.
    assign Mult_Result_In = Mult_Enable_Out ? ({8'h00, Mult_Data_A_Out} * {8'h00, Mult_Data_B_Out})
                                            : 16'hDEAD;

    unsigned_multiplier_arbiter #(.NUM_REQ(4), .ID_WIDTH(2)) dut (
        .Clock_In        (Clock_In),
        .Reset_N_In      (Reset_N_In),
        .Req_Valid_In    (Req_Valid_In),
        .Req_Ready_Out   (Req_Ready_Out),
        .Req_Data_A_In   (Req_Data_A_In),
        .Req_Data_B_In   (Req_Data_B_In),
        .Mult_Enable_Out (Mult_Enable_Out),
        .Mult_Data_A_Out (Mult_Data_A_Out),
        .Mult_Data_B_Out (Mult_Data_B_Out),
        .Mult_Result_In  (Mult_Result_In),
        .Resp_Valid_Out  (Resp_Valid_Out),
        .Resp_Ready_In   (Resp_Ready_In),
        .Resp_Result_Out (Resp_Result_Out),
        .Resp_Id_Out     (Resp_Id_Out),
        .Ops_Count_Out   (Ops_Count_Out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clock_In);
        #1;
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
        Req_Data_A_In[8*id +: 8] = a;
        Req_Data_B_In[8*id +: 8] = b;
    endtask

    task automatic do_reset();
        Reset_N_In   = 1'b0;
        Req_Valid_In = '0;
        cyc();
        cyc();
        Reset_N_In = 1'b1;
    endtask

    // Single operation with Resp_Ready_In high; entered and left just after a rising edge.
    task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        logic [3:0] want;
        bit         seen;
        want = 4'b0001 << id;
        seen = 1'b0;
        set_req(id, a, b);
        Req_Valid_In  = want;
        Resp_Ready_In = 1'b1;
        sb_q.push_back('{id: 2'(id), res: exp});
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge Clock_In);
            if (Req_Ready_Out != 4'b0000) seen = 1'b1;
            else cyc();
        end
        chk("run_op_grant", 32'(Req_Ready_Out), 32'(want));
        cyc();
        Req_Valid_In = '0;
        repeat (3) @(negedge Clock_In);
        cyc();
    endtask

    function automatic logic [3:0] rr_model(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return 4'b0001 << ((p + k) % 4);
        end
        return 4'b0000;
    endfunction

    // Response monitor: compares on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock_In);
            if (Resp_Valid_Out && Resp_Ready_In) begin
                if (sb_q.size() == 0) begin
                    chk("resp_unexpected", 32'(Resp_Result_Out), 32'hFFFFFFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_id", 32'(Resp_Id_Out), 32'(e.id));
                    chk("resp_result", 32'(Resp_Result_Out), 32'(e.res));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         en_cnt;
        int         st;
        int         ptr;
        int         granted;
        int         cycles;
        int         gid;
        int         wt[4];
        logic [3:0] v;
        logic [3:0] eg;
        logic [7:0] ra[4];
        logic [7:0] rb[4];

        Reset_N_In    = 1'b0;
        Req_Valid_In  = '0;
        Req_Data_A_In = '0;
        Req_Data_B_In = '0;
        Resp_Ready_In = 1'b0;
        @(posedge Clock_In);
        @(negedge Clock_In);
        chk("rst_ready", 32'(Req_Ready_Out), 32'h0);
        chk("rst_mult_en", 32'(Mult_Enable_Out), 32'h0);
        chk("rst_mult_a", 32'(Mult_Data_A_Out), 32'h0);
        chk("rst_mult_b", 32'(Mult_Data_B_Out), 32'h0);
        chk("rst_resp_valid", 32'(Resp_Valid_Out), 32'h0);
        chk("rst_resp_result", 32'(Resp_Result_Out), 32'h0);
        chk("rst_resp_id", 32'(Resp_Id_Out), 32'h0);
        chk("rst_ops", 32'(Ops_Count_Out), 32'h0);
        cyc();
        Reset_N_In = 1'b1;

        // Single request from requester 1, 0xFF*0xFF.
        set_req(1, 8'hFF, 8'hFF);
        Req_Valid_In  = 4'b0010;
        Resp_Ready_In = 1'b1;
        @(negedge Clock_In);
        chk("single_grant_c0", 32'(Req_Ready_Out), 32'h2);
        sb_q.push_back('{id: 2'd1, res: 16'hFE01});
        cyc();
        Req_Valid_In = '0;
        @(negedge Clock_In);
        chk("single_en_c1", 32'(Mult_Enable_Out), 32'h1);
        chk("single_mult_a", 32'(Mult_Data_A_Out), 32'hFF);
        chk("single_mult_b", 32'(Mult_Data_B_Out), 32'hFF);
        chk("single_rvalid_c1", 32'(Resp_Valid_Out), 32'h0);
        @(negedge Clock_In);
        chk("single_rvalid_c2", 32'(Resp_Valid_Out), 32'h1);
        chk("single_en_c2", 32'(Mult_Enable_Out), 32'h0);
        @(negedge Clock_In);
        chk("single_ops", 32'(Ops_Count_Out), 32'h1);
        chk("single_rvalid_c3", 32'(Resp_Valid_Out), 32'h0);
        cyc();

        // All four requesters continuously valid from reset.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 2), 8'd3);
        sb_q.push_back('{id: 2'd0, res: 16'd6});
        sb_q.push_back('{id: 2'd1, res: 16'd9});
        sb_q.push_back('{id: 2'd2, res: 16'd12});
        sb_q.push_back('{id: 2'd3, res: 16'd15});
        sb_q.push_back('{id: 2'd0, res: 16'd6});
        Req_Valid_In  = 4'b1111;
        Resp_Ready_In = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge Clock_In);
            chk("rr_grant", 32'(Req_Ready_Out), (c % 3 == 0) ? (32'h1 << ((c / 3) % 4)) : 32'h0);
            cyc();
        end
        Req_Valid_In = '0;
        repeat (3) @(negedge Clock_In);
        chk("rr_ops", 32'(Ops_Count_Out), 32'd5);
        chk("rr_drained", 32'(sb_q.size()), 32'd0);
        cyc();

        // Backpressure: 0x12*0x34 held ten cycles while requester 0 waits.
        set_req(2, 8'h12, 8'h34);
        set_req(0, 8'h01, 8'h01);
        Req_Valid_In  = 4'b0101;
        Resp_Ready_In = 1'b0;
        @(negedge Clock_In);
        chk("bp_grant", 32'(Req_Ready_Out), 32'h4);
        sb_q.push_back('{id: 2'd2, res: 16'h03A8});
        cyc();
        Req_Valid_In = 4'b0001;
        en_cnt = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge Clock_In);
            en_cnt += int'(Mult_Enable_Out);
            chk("bp_no_ready", 32'(Req_Ready_Out), 32'h0);
            if (c >= 2) begin
                chk("bp_rvalid", 32'(Resp_Valid_Out), 32'h1);
                chk("bp_result_stable", 32'(Resp_Result_Out), 32'h03A8);
                chk("bp_id_stable", 32'(Resp_Id_Out), 32'h2);
            end
            cyc();
        end
        chk("bp_en_once", 32'(en_cnt), 32'd1);
        Resp_Ready_In = 1'b1;
        sb_q.push_back('{id: 2'd0, res: 16'h0001});
        @(negedge Clock_In);
        chk("bp_release_no_ready", 32'(Req_Ready_Out), 32'h0);
        cyc();
        @(negedge Clock_In);
        chk("bp_next_grant", 32'(Req_Ready_Out), 32'h1);
        cyc();
        Req_Valid_In = '0;
        repeat (3) @(negedge Clock_In);
        chk("bp_ops", 32'(Ops_Count_Out), 32'd7);
        chk("bp_drained", 32'(sb_q.size()), 32'd0);
        cyc();

        // Reset while in EXEC.
        set_req(3, 8'h05, 8'h07);
        Req_Valid_In = 4'b1000;
        @(negedge Clock_In);
        chk("rexec_grant", 32'(Req_Ready_Out), 32'h8);
        cyc();
        Req_Valid_In = '0;
        Reset_N_In   = 1'b0;
        @(negedge Clock_In);
        chk("rexec_in_exec", 32'(Mult_Enable_Out), 32'h1);
        cyc();
        Reset_N_In = 1'b1;
        @(negedge Clock_In);
        chk("rexec_en", 32'(Mult_Enable_Out), 32'h0);
        chk("rexec_rvalid", 32'(Resp_Valid_Out), 32'h0);
        chk("rexec_ops", 32'(Ops_Count_Out), 32'h0);
        cyc();
        @(negedge Clock_In);
        chk("rexec_stays_idle", 32'(Resp_Valid_Out), 32'h0);
        cyc();

        // Reset while in RESULT.
        set_req(1, 8'h03, 8'h04);
        Req_Valid_In  = 4'b0010;
        Resp_Ready_In = 1'b0;
        @(negedge Clock_In);
        chk("rres_grant", 32'(Req_Ready_Out), 32'h2);
        cyc();
        Req_Valid_In = '0;
        cyc();
        @(negedge Clock_In);
        chk("rres_rvalid_before", 32'(Resp_Valid_Out), 32'h1);
        chk("rres_result_before", 32'(Resp_Result_Out), 32'd12);
        cyc();
        Reset_N_In = 1'b0;
        cyc();
        Reset_N_In = 1'b1;
        @(negedge Clock_In);
        chk("rres_rvalid", 32'(Resp_Valid_Out), 32'h0);
        chk("rres_result", 32'(Resp_Result_Out), 32'h0);
        chk("rres_ops", 32'(Ops_Count_Out), 32'h0);
        cyc();
        run_op(2, 8'h10, 8'h10, 16'h0100);
        chk("fresh_ops", 32'(Ops_Count_Out), 32'd1);

        // Counter wrap with zero operands.
        @(negedge Clock_In);
        force dut.r_ops_count = 16'hFFFF;
        @(negedge Clock_In);
        release dut.r_ops_count;
        cyc();
        chk("wrap_preload", 32'(Ops_Count_Out), 32'hFFFF);
        run_op(0, 8'h00, 8'h5A, 16'h0000);
        chk("wrap_to_zero", 32'(Ops_Count_Out), 32'h0);
        run_op(1, 8'h77, 8'h00, 16'h0000);
        chk("wrap_after", 32'(Ops_Count_Out), 32'h1);

        // Random traffic against a cycle model of the handshake sequence.
        do_reset();
        st      = 0;
        ptr     = 0;
        granted = 0;
        cycles  = 0;
        v       = '0;
        for (int i = 0; i < 4; i++) begin
            wt[i] = 0;
            ra[i] = '0;
            rb[i] = '0;
        end
        while (granted < 1000 && cycles < 20000) begin
            for (int i = 0; i < 4; i++) begin
                if (!v[i] && $urandom_range(0, 3) == 0) begin
                    v[i]  = 1'b1;
                    ra[i] = 8'($urandom_range(0, 255));
                    rb[i] = 8'($urandom_range(0, 255));
                end
                Req_Data_A_In[8*i +: 8] = ra[i];
                Req_Data_B_In[8*i +: 8] = rb[i];
            end
            Req_Valid_In  = v;
            Resp_Ready_In = ($urandom_range(0, 2) != 0);
            @(negedge Clock_In);
            eg = (st == 0) ? rr_model(v, ptr) : 4'b0000;
            chk("rand_grant", 32'(Req_Ready_Out), 32'(eg));
            chk("rand_mult_en", 32'(Mult_Enable_Out), (st == 1) ? 32'h1 : 32'h0);
            chk("rand_rvalid", 32'(Resp_Valid_Out), (st == 2) ? 32'h1 : 32'h0);
            if (st == 0 && eg != 4'b0000) begin
                gid = 0;
                for (int i = 0; i < 4; i++) if (eg[i]) gid = i;
                sb_q.push_back('{id: 2'(gid), res: {8'h00, ra[gid]} * {8'h00, rb[gid]}});
                chk("rand_starve", (wt[gid] <= 3) ? 32'h1 : 32'h0, 32'h1);
                for (int i = 0; i < 4; i++) if (v[i] && i != gid) wt[i]++;
                wt[gid] = 0;
                v[gid]  = 1'b0;
                ptr     = (gid + 1) % 4;
                st      = 1;
                granted++;
            end else if (st == 1) begin
                st = 2;
            end else if (st == 2 && Resp_Ready_In) begin
                st = 0;
            end
            cyc();
            cycles++;
        end
        Req_Valid_In  = '0;
        Resp_Ready_In = 1'b1;
        repeat (6) cyc();
        chk("rand_done", 32'(granted), 32'd1000);
        chk("rand_drained", 32'(sb_q.size()), 32'd0);
        chk("rand_ops", 32'(Ops_Count_Out), 32'(granted));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
